csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter HARTID, default 32'h0, value returned by mhartid (0xF14).
REQ-002 SHALL have parameter MISA_VAL, default 32'h40001120 (RV32IMF), value returned by misa (0x301).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 csr_req  input  1  CSR access request, one-cycle pulse.
REQ-006 csr_op  input  2  01 RW, 10 RS (set), 11 RC (clear), 00 no-op read.
REQ-007 csr_addr  input  12  CSR address.
REQ-008 csr_wdata  input  32  rs1 value or zero-extended zimm.
REQ-009 csr_src_zero  input  1  rs1 is x0 or zimm==0; suppresses the write for RS/RC.
REQ-010 csr_ack  output  1  registered response strobe.
REQ-011 csr_rdata  output  32  registered old CSR value.
REQ-012 csr_illegal  output  1  registered, valid with csr_ack.
REQ-013 instr_retire  input  1  one instruction retired this cycle.
REQ-014 fpu_flags_valid  input  1  fpu_flags valid this cycle.
REQ-015 fpu_flags  input  5  NV,DZ,OF,UF,NX exception flags.
REQ-016 frm  output  3  current rounding mode.
REQ-017 trap_req  input  1  take a trap this cycle.
REQ-018 trap_pc  input  32  faulting PC.
REQ-019 trap_cause  input  32  mcause value.
REQ-020 mret  input  1  MRET executed this cycle.
REQ-021 trap_vector  output  32  mtvec, combinational.
REQ-022 epc  output  32  mepc, combinational.
REQ-023 mie  output  1  mstatus.MIE, combinational.

Function
REQ-024 Implemented CSRs SHALL be: fflags 0x001, frm 0x002, fcsr 0x003 ({24'b0,frm,fflags}), mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11 read 2'b11, others 0), misa, mtvec 0x305 (bits 1:0 read 0), mscratch 0x340, mepc 0x341 (bits 1:0 read 0), mcause 0x342, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82, mhartid.
REQ-025 Request sampled at edge N SHALL produce csr_ack=1 for exactly one cycle after edge N+1 latches it, with csr_rdata = value before the access; back-to-back requests SHALL be accepted every cycle.
REQ-026 New value: RW → wdata; RS → old|wdata; RC → old&~wdata; written at the same edge that raises csr_ack.
REQ-027 Write SHALL be suppressed for op 00, and for RS/RC when csr_src_zero=1.
REQ-028 Unimplemented address, or effective write to addr[11:10]==2'b11, SHALL give csr_illegal=1, csr_rdata=0, no state change; csr_ack still asserted.
REQ-029 mcycle (64-bit) SHALL increment every cycle; minstret (64-bit) SHALL increment when instr_retire=1; both wrap 2^64-1 → 0.
REQ-030 CSR write to a counter half SHALL win over that cycle's increment; carry from the low half SHALL not apply when either half is written that cycle.
REQ-031 fflags SHALL OR-accumulate fpu_flags when fpu_flags_valid=1; a CSR write to fflags/fcsr in the same cycle SHALL win.
REQ-032 trap_req SHALL set mepc=trap_pc&~3, mcause=trap_cause, MPIE=MIE, MIE=0.
REQ-033 mret (no trap_req) SHALL set MIE=MPIE, MPIE=1.
REQ-034 Priority same cycle: trap_req > mret > CSR write for mstatus/mepc/mcause; CSR rdata still returns old value, CSR write to those three is dropped.
REQ-035 frm values 5/6 SHALL be stored as written (no legalisation).

Reset
REQ-036 rst=1 SHALL asynchronously clear csr_ack, csr_illegal, csr_rdata, all counters, fflags, frm, mstatus MIE/MPIE, mtvec, mepc, mcause, mscratch to 0.
REQ-037 A request sampled in the cycle rst deasserts SHALL be processed normally; one in flight during rst SHALL be discarded (no ack).

Verification
REQ-038 RW mscratch 0xDEADBEEF then RS 0x0000000F then RC 0x000000F0 → rdata 0, 0xDEADBEEF, 0xDEADBEEF; final mscratch 0xDEADBE0F.
REQ-039 Write mtvec 0x00000103 → trap_vector 0x00000100; RS mtvec with csr_src_zero=1, wdata 0xFF → no change.
REQ-040 Preload mcycle 0xFFFFFFFF → next cycle mcycle 0, mcycleh 1; write cycle 0xC00 → csr_illegal=1, value unchanged.
REQ-041 fpu_flags 5'b00001 then 5'b10000 → fflags 0x11; same-cycle fcsr RW 0x0E0 with flags 5'b00100 → frm 7, fflags 0.
REQ-042 MIE=1, trap_req pc 0x00000206 cause 0x8000000B → epc 0x00000204, mie 0, MPIE 1; mret → mie 1.
REQ-043 Assert rst mid-request → no csr_ack, all outputs 0; read 0x7C0 → csr_illegal=1, rdata 0.

Source files
------------

// File: rtl/csr_if.sv
// CSR access channel between the pipeline (master) and the CSR file (slave):
// a one-cycle request and its registered response one cycle later.
interface csr_if;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_src_zero;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_req,
        output csr_op,
        output csr_addr,
        output csr_wdata,
        output csr_src_zero,
        input  csr_ack,
        input  csr_rdata,
        input  csr_illegal
    );

    modport slave (
        input  csr_req,
        input  csr_op,
        input  csr_addr,
        input  csr_wdata,
        input  csr_src_zero,
        output csr_ack,
        output csr_rdata,
        output csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for an RV32IMF hart: latched CSR access with registered
// response, 64-bit cycle/instret counters, FP status and trap/MRET bookkeeping.
module csr_file #(
    parameter logic [31:0] HARTID   = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL = 32'h4000_1120
) (
    input  logic        clk,
    input  logic        rst,
    csr_if.slave        bus,
    input  logic        instr_retire,
    input  logic        fpu_flags_valid,
    input  logic [4:0]  fpu_flags,
    output logic [2:0]  frm,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    output logic [31:0] trap_vector,
    output logic [31:0] epc,
    output logic        mie
);

    localparam logic [11:0] A_FFLAGS    = 12'h001;
    localparam logic [11:0] A_FRM       = 12'h002;
    localparam logic [11:0] A_FCSR      = 12'h003;
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] csr_modify(
        input logic [1:0]  op,
        input logic [31:0] old_val,
        input logic [31:0] wval
    );
        logic [31:0] res;
        case (op)
            OP_RW:   res = wval;
            OP_RS:   res = old_val | wval;
            OP_RC:   res = old_val & ~wval;
            default: res = old_val;
        endcase
        return res;
    endfunction

    logic        req_q, req_d;
    logic [1:0]  op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        src_zero_q, src_zero_d;

    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic [4:0]  fflags_q, fflags_d;
    logic [2:0]  frm_q, frm_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;

    logic        hit_s;
    logic [31:0] old_s;
    logic [31:0] new_s;
    logic        wr_req_s;
    logic        illegal_s;
    logic        wr_s;

    // Read mux over the latched address; hit_s flags an implemented CSR.
    always_comb begin
        hit_s = 1'b1;
        old_s = 32'h0000_0000;
        case (addr_q)
            A_FFLAGS:                old_s = {27'h0, fflags_q};
            A_FRM:                   old_s = {29'h0, frm_q};
            A_FCSR:                  old_s = {24'h0, frm_q, fflags_q};
            A_MSTATUS:               old_s = {19'h0, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
            A_MISA:                  old_s = MISA_VAL;
            A_MTVEC:                 old_s = mtvec_q;
            A_MSCRATCH:              old_s = mscratch_q;
            A_MEPC:                  old_s = mepc_q;
            A_MCAUSE:                old_s = mcause_q;
            A_MCYCLE,   A_CYCLE:     old_s = mcycle_q[31:0];
            A_MCYCLEH,  A_CYCLEH:    old_s = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:   old_s = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH: old_s = minstret_q[63:32];
            A_MHARTID:               old_s = HARTID;
            default: begin
                hit_s = 1'b0;
                old_s = 32'h0000_0000;
            end
        endcase
    end

    // Access decode: RS/RC with a zero source are pure reads and may touch read-only space.
    always_comb begin
        wr_req_s = 1'b0;
        if (!req_q) begin
            wr_req_s = 1'b0;
        end else if (op_q == OP_RW) begin
            wr_req_s = 1'b1;
        end else if (op_q != OP_READ) begin
            wr_req_s = !src_zero_q;
        end else begin
            wr_req_s = 1'b0;
        end
        illegal_s = req_q && (!hit_s || (wr_req_s && (addr_q[11:10] == 2'b11)));
        wr_s      = wr_req_s && !illegal_s;
        new_s     = csr_modify(op_q, old_s, wdata_q);
    end

    // Request latch and response registers.
    always_comb begin
        req_d      = bus.csr_req;
        op_d       = bus.csr_op;
        addr_d     = bus.csr_addr;
        wdata_d    = bus.csr_wdata;
        src_zero_d = bus.csr_src_zero;
        ack_d      = req_q;
        illegal_d  = illegal_s;
        if (req_q) begin
            rdata_d = illegal_s ? 32'h0000_0000 : old_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Counters: a written half wins over the increment and blocks the low-to-high carry.
    always_comb begin
        if (wr_s && (addr_q == A_MCYCLE)) begin
            mcycle_d = {mcycle_q[63:32], new_s};
        end else if (wr_s && (addr_q == A_MCYCLEH)) begin
            mcycle_d = {new_s, mcycle_q[31:0] + 32'h0000_0001};
        end else begin
            mcycle_d = mcycle_q + 64'h1;
        end

        if (wr_s && (addr_q == A_MINSTRET)) begin
            minstret_d = {minstret_q[63:32], new_s};
        end else if (wr_s && (addr_q == A_MINSTRETH)) begin
            minstret_d = {new_s, minstret_q[31:0] + {31'h0, instr_retire}};
        end else begin
            minstret_d = minstret_q + {63'h0, instr_retire};
        end
    end

    // FP status: CSR writes override the sticky accumulation of FPU flags.
    always_comb begin
        if (wr_s && ((addr_q == A_FFLAGS) || (addr_q == A_FCSR))) begin
            fflags_d = new_s[4:0];
        end else if (fpu_flags_valid) begin
            fflags_d = fflags_q | fpu_flags;
        end else begin
            fflags_d = fflags_q;
        end

        if (wr_s && (addr_q == A_FRM)) begin
            frm_d = new_s[2:0];
        end else if (wr_s && (addr_q == A_FCSR)) begin
            frm_d = new_s[7:5];
        end else begin
            frm_d = frm_q;
        end
    end

    // Trap state: trap beats MRET, and both drop any CSR write to mstatus/mepc/mcause.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (trap_req) begin
            mepc_d   = trap_pc & ALIGN4_MASK;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_s) begin
            case (addr_q)
                A_MSTATUS: begin
                    mie_d  = new_s[3];
                    mpie_d = new_s[7];
                end
                A_MEPC:   mepc_d   = new_s & ALIGN4_MASK;
                A_MCAUSE: mcause_d = new_s;
                default:  mcause_d = mcause_q;
            endcase
        end else begin
            mie_d = mie_q;
        end

        if (wr_s && (addr_q == A_MTVEC)) begin
            mtvec_d = new_s & ALIGN4_MASK;
        end else begin
            mtvec_d = mtvec_q;
        end

        if (wr_s && (addr_q == A_MSCRATCH)) begin
            mscratch_d = new_s;
        end else begin
            mscratch_d = mscratch_q;
        end
    end

    // All state; reset also discards a request still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            op_q       <= 2'b00;
            addr_q     <= 12'h000;
            wdata_q    <= 32'h0000_0000;
            src_zero_q <= 1'b0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
            fflags_q   <= 5'h00;
            frm_q      <= 3'h0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= 32'h0000_0000;
            mscratch_q <= 32'h0000_0000;
            mepc_q     <= 32'h0000_0000;
            mcause_q   <= 32'h0000_0000;
            ack_q      <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            illegal_q  <= 1'b0;
        end else begin
            req_q      <= req_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            src_zero_q <= src_zero_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            fflags_q   <= fflags_d;
            frm_q      <= frm_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.csr_ack     = ack_q;
    assign bus.csr_rdata   = rdata_q;
    assign bus.csr_illegal = illegal_q;
    assign frm             = frm_q;
    assign trap_vector     = mtvec_q;
    assign epc             = mepc_q;
    assign mie             = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: random + directed stimulus, an abstract CSR model, and a
// scoreboard queue drained by an independent response monitor.
module tb_csr_file;
    localparam logic [31:0] HARTID = 32'h0000_0005;
    localparam logic [31:0] MISA   = 32'h4000_1120;

    logic        clk;
    logic        rst;
    logic        instr_retire;
    logic        fpu_flags_valid;
    logic [4:0]  fpu_flags;
    logic [2:0]  frm;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret;
    logic [31:0] trap_vector;
    logic [31:0] epc;
    logic        mie;

    csr_if bus_if();

    csr_file #(.HARTID(HARTID), .MISA_VAL(MISA)) dut (
        .clk(clk), .rst(rst), .bus(bus_if),
        .instr_retire(instr_retire), .fpu_flags_valid(fpu_flags_valid), .fpu_flags(fpu_flags),
        .frm(frm), .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret(mret), .trap_vector(trap_vector), .epc(epc), .mie(mie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    // Reference state, kept as plain architectural values.
    logic [63:0] m_mcycle, m_minstret;
    logic [4:0]  m_fflags;
    logic [2:0]  m_frm;
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic        p_w;
    logic [11:0] p_a;
    logic [31:0] p_nv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic ref_read(input logic [11:0] a, output logic [31:0] v);
        logic ok;
        ok = 1'b1;
        case (a)
            12'h001: v = {27'h0, m_fflags};
            12'h002: v = {29'h0, m_frm};
            12'h003: v = {24'h0, m_frm, m_fflags};
            12'h300: v = 32'h0000_1800 | (m_mpie ? 32'h0000_0080 : 32'h0) | (m_mie ? 32'h0000_0008 : 32'h0);
            12'h301: v = MISA;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00, 12'hC00: v = m_mcycle[31:0];
            12'hB80, 12'hC80: v = m_mcycle[63:32];
            12'hB02, 12'hC02: v = m_minstret[31:0];
            12'hB82, 12'hC82: v = m_minstret[63:32];
            12'hF14: v = HARTID;
            default: begin v = 32'h0; ok = 1'b0; end
        endcase
        return ok;
    endfunction

    task automatic model_reset();
        m_mcycle = 64'h0; m_minstret = 64'h0; m_fflags = 5'h0; m_frm = 3'h0;
        m_mie = 1'b0; m_mpie = 1'b0; m_mtvec = 32'h0; m_mscratch = 32'h0;
        m_mepc = 32'h0; m_mcause = 32'h0; p_w = 1'b0; p_a = 12'h0; p_nv = 32'h0;
        sb_q.delete();
    endtask

    // One rising edge of the reference: apply last cycle's access, events, then log the new request.
    task automatic model_step();
        logic [31:0] old_v, nv, wd;
        logic        ok, eff, ill, lo_w, hi_w;
        logic [1:0]  op;
        logic [11:0] a;
        exp_t        e;
        edge_cnt++;
        lo_w = p_w && (p_a == 12'hB00);
        hi_w = p_w && (p_a == 12'hB80);
        if (lo_w || hi_w) begin
            m_mcycle[31:0] = lo_w ? p_nv : m_mcycle[31:0] + 32'd1;
            if (hi_w) m_mcycle[63:32] = p_nv;
        end else m_mcycle = m_mcycle + 64'd1;
        lo_w = p_w && (p_a == 12'hB02);
        hi_w = p_w && (p_a == 12'hB82);
        if (lo_w || hi_w) begin
            m_minstret[31:0] = lo_w ? p_nv : m_minstret[31:0] + {31'h0, instr_retire};
            if (hi_w) m_minstret[63:32] = p_nv;
        end else m_minstret = m_minstret + {63'h0, instr_retire};
        if (p_w && (p_a == 12'h001 || p_a == 12'h003)) m_fflags = p_nv[4:0];
        else if (fpu_flags_valid) m_fflags = m_fflags | fpu_flags;
        if (p_w && p_a == 12'h002) m_frm = p_nv[2:0];
        else if (p_w && p_a == 12'h003) m_frm = p_nv[7:5];
        if (trap_req) begin
            m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mpie = m_mie; m_mie = 1'b0;
        end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1'b1;
        end else if (p_w && p_a == 12'h300) begin
            m_mie = p_nv[3]; m_mpie = p_nv[7];
        end else if (p_w && p_a == 12'h341) m_mepc = p_nv & ~32'h3;
        else if (p_w && p_a == 12'h342) m_mcause = p_nv;
        if (p_w && p_a == 12'h305) m_mtvec = p_nv & ~32'h3;
        if (p_w && p_a == 12'h340) m_mscratch = p_nv;
        p_w = 1'b0;
        if (bus_if.csr_req) begin
            op = bus_if.csr_op; a = bus_if.csr_addr; wd = bus_if.csr_wdata;
            ok  = ref_read(a, old_v);
            eff = (op == 2'b01) || ((op != 2'b00) && !bus_if.csr_src_zero);
            ill = !ok || (eff && (a[11:10] == 2'b11));
            case (op)
                2'b01:   nv = wd;
                2'b10:   nv = old_v | wd;
                2'b11:   nv = old_v & ~wd;
                default: nv = old_v;
            endcase
            e.rdata = ill ? 32'h0 : old_v; e.ill = ill; e.due = edge_cnt + 1;
            sb_q.push_back(e);
            p_w = eff && !ill; p_a = a; p_nv = nv;
        end
    endtask

    // Monitor: each falling edge, ack must match the scoreboard head's due cycle.
    initial begin
        exp_t e;
        logic exp_ack;
        forever begin
            @(negedge clk);
            exp_ack = 1'b0;
            if (sb_q.size() > 0) exp_ack = (sb_q[0].due == edge_cnt);
            chk("ack", {31'h0, bus_if.csr_ack}, {31'h0, exp_ack});
            if (exp_ack) begin
                e = sb_q.pop_front();
                chk("rdata", bus_if.csr_rdata, e.rdata);
                chk("illegal", {31'h0, bus_if.csr_illegal}, {31'h0, e.ill});
            end
            chk("frm", {29'h0, frm}, {29'h0, m_frm});
            chk("trap_vector", trap_vector, m_mtvec);
            chk("epc", epc, m_mepc);
            chk("mie", {31'h0, mie}, {31'h0, m_mie});
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        #2;
        bus_if.csr_req = 1'b0; instr_retire = 1'b0; fpu_flags_valid = 1'b0;
        trap_req = 1'b0; mret = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic sz);
        bus_if.csr_req = 1'b1; bus_if.csr_op = op; bus_if.csr_addr = a;
        bus_if.csr_wdata = wd; bus_if.csr_src_zero = sz;
    endtask

    task automatic access(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic sz);
        set_req(op, a, wd, sz);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    function automatic logic [11:0] pick_addr(input int k);
        case (k)
            0: return 12'h001;  1: return 12'h002;  2: return 12'h003;  3: return 12'h300;
            4: return 12'h301;  5: return 12'h305;  6: return 12'h340;  7: return 12'h341;
            8: return 12'h342;  9: return 12'hB00; 10: return 12'hB80; 11: return 12'hB02;
            12: return 12'hB82; 13: return 12'hC00; 14: return 12'hC80; 15: return 12'hC02;
            16: return 12'hC82; 17: return 12'hF14; 18: return 12'h123; 19: return 12'hF11;
            20: return 12'h304;
            default: return 12'h7C0;
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        bus_if.csr_req = 1'b0; bus_if.csr_op = 2'b00; bus_if.csr_addr = 12'h0;
        bus_if.csr_wdata = 32'h0; bus_if.csr_src_zero = 1'b0;
        instr_retire = 1'b0; fpu_flags_valid = 1'b0; fpu_flags = 5'h0;
        trap_req = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0; mret = 1'b0;
        model_reset();
        #1;
        do_reset();
        chk("reset_ack", {31'h0, bus_if.csr_ack}, 32'h0);
        chk("reset_rdata", bus_if.csr_rdata, 32'h0);

        // Back-to-back mscratch RW / RS / RC.
        set_req(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0); tick();
        set_req(2'b10, 12'h340, 32'h0000_000F, 1'b0); tick();
        chk("b2b_rw_old", bus_if.csr_rdata, 32'h0000_0000);
        set_req(2'b11, 12'h340, 32'h0000_00F0, 1'b0); tick();
        chk("b2b_rs_old", bus_if.csr_rdata, 32'hDEAD_BEEF);
        tick();
        chk("b2b_rc_old", bus_if.csr_rdata, 32'hDEAD_BEEF);
        access(2'b00, 12'h340, 32'h0, 1'b0);
        chk("mscratch_final", bus_if.csr_rdata, 32'hDEAD_BE0F);

        // mtvec alignment and suppressed RS.
        access(2'b01, 12'h305, 32'h0000_0103, 1'b0);
        chk("mtvec_align", trap_vector, 32'h0000_0100);
        access(2'b10, 12'h305, 32'h0000_00FF, 1'b1);
        chk("mtvec_rs_zero", trap_vector, 32'h0000_0100);
        chk("mtvec_rs_zero_ill", {31'h0, bus_if.csr_illegal}, 32'h0);

        // mcycle carry and read-only shadow.
        access(2'b01, 12'hB80, 32'h0, 1'b0);
        access(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        access(2'b00, 12'hB00, 32'h0, 1'b0);
        chk("mcycle_wrap_lo", bus_if.csr_rdata, 32'h0000_0000);
        access(2'b00, 12'hB80, 32'h0, 1'b0);
        chk("mcycle_wrap_hi", bus_if.csr_rdata, 32'h0000_0001);
        access(2'b01, 12'hC00, 32'h0000_0005, 1'b0);
        chk("cycle_wr_ill", {31'h0, bus_if.csr_illegal}, 32'h1);
        chk("cycle_wr_rdata", bus_if.csr_rdata, 32'h0);

        // fflags accumulation, then fcsr write racing new flags.
        fpu_flags_valid = 1'b1; fpu_flags = 5'b00001; tick();
        fpu_flags_valid = 1'b1; fpu_flags = 5'b10000; tick();
        access(2'b00, 12'h001, 32'h0, 1'b0);
        chk("fflags_acc", bus_if.csr_rdata, 32'h0000_0011);
        set_req(2'b01, 12'h003, 32'h0000_00E0, 1'b0); tick();
        fpu_flags_valid = 1'b1; fpu_flags = 5'b00100; tick();
        chk("fcsr_frm", {29'h0, frm}, 32'h7);
        access(2'b00, 12'h001, 32'h0, 1'b0);
        chk("fcsr_fflags", bus_if.csr_rdata, 32'h0);

        // Trap entry and MRET.
        access(2'b01, 12'h300, 32'h0000_0008, 1'b0);
        chk("mie_set", {31'h0, mie}, 32'h1);
        trap_req = 1'b1; trap_pc = 32'h0000_0206; trap_cause = 32'h8000_000B; tick();
        chk("trap_epc", epc, 32'h0000_0204);
        chk("trap_mie", {31'h0, mie}, 32'h0);
        access(2'b00, 12'h300, 32'h0, 1'b0);
        chk("trap_mstatus", bus_if.csr_rdata, 32'h0000_1880);
        mret = 1'b1; tick();
        chk("mret_mie", {31'h0, mie}, 32'h1);

        // Reset with a request in flight, then an unimplemented read.
        set_req(2'b00, 12'h340, 32'h0, 1'b0); tick();
        do_reset();
        chk("rst_ack", {31'h0, bus_if.csr_ack}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_mie", {31'h0, mie}, 32'h0);
        access(2'b00, 12'h7C0, 32'h0, 1'b0);
        chk("unimpl_ill", {31'h0, bus_if.csr_illegal}, 32'h1);
        chk("unimpl_rdata", bus_if.csr_rdata, 32'h0);

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0)
                set_req(2'($urandom_range(0, 3)), pick_addr($urandom_range(0, 21)), $urandom,
                        ($urandom_range(0, 3) == 0));
            instr_retire    = 1'($urandom_range(0, 1));
            fpu_flags_valid = ($urandom_range(0, 3) == 0);
            fpu_flags       = 5'($urandom_range(0, 31));
            trap_req        = ($urandom_range(0, 15) == 0);
            trap_pc         = $urandom;
            trap_cause      = $urandom;
            mret            = ($urandom_range(0, 15) == 0);
            tick();
            if (i == 700) do_reset();
        end

        repeat (3) tick();
        chk("sb_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
